// File: rtl/wb_arbiter.sv
// Two-master round-robin Wishbone arbiter that drives one shared slave port.
// Define WB_ARB_TIMEOUT_EN to add the busy-cycle counter and the one-cycle TOUT error state.
module wb_arbiter #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_STB,
  input  logic              m0_WE,
  input  logic [ADDR_W-1:0] m0_ADDR,
  input  logic [DATA_W-1:0] m0_DAT_I,
  output logic [DATA_W-1:0] m0_DAT_O,
  output logic              m0_ACK,
  output logic              m0_ERR,
  input  logic              m1_STB,
  input  logic              m1_WE,
  input  logic [ADDR_W-1:0] m1_ADDR,
  input  logic [DATA_W-1:0] m1_DAT_I,
  output logic [DATA_W-1:0] m1_DAT_O,
  output logic              m1_ACK,
  output logic              m1_ERR,
  output logic              s_STB,
  output logic              s_WE,
  output logic [ADDR_W-1:0] s_ADDR,
  output logic [DATA_W-1:0] s_DAT_O,
  input  logic [DATA_W-1:0] s_DAT_I,
  input  logic              s_ACK,
  output logic [1:0]        grant
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
`ifdef WB_ARB_TIMEOUT_EN
  localparam logic [1:0]  ST_TOUT  = 2'd2;
  localparam logic [16:0] LP_LIMIT = 17'(TIMEOUT_CYCLES);
`endif

  logic [1:0] r_state;
  logic       r_owner;
  logic       r_last;
  logic [1:0] r_grant;

  logic w_busy;
  logic w_own_stb;
  logic w_any_req;
  logic w_winner;

  assign w_busy    = (r_state == ST_BUSY);
  assign w_own_stb = r_owner ? m1_STB : m0_STB;
  assign w_any_req = m0_STB | m1_STB;
  // On a tie the master that was not served last wins; otherwise the lone requester.
  assign w_winner  = (m0_STB & m1_STB) ? ~r_last : m1_STB;

`ifdef WB_ARB_TIMEOUT_EN
  logic [15:0] r_cnt;
  logic        w_expire;

  assign w_expire = (({1'b0, r_cnt} + 17'd1) == LP_LIMIT);

  // Cleared throughout IDLE so every BUSY entry starts counting from zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (r_state == ST_IDLE) begin
      r_cnt <= '0;
    end else if (w_busy && !s_ACK) begin
      r_cnt <= r_cnt + 16'd1;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_owner <= 1'b0;
      r_last  <= 1'b1;
      r_grant <= 2'b00;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_any_req) begin
            r_state <= ST_BUSY;
            r_owner <= w_winner;
            r_grant <= w_winner ? 2'b10 : 2'b01;
          end
        end
        ST_BUSY: begin
          // An acknowledge always wins over an abort or an expiring counter.
          if (s_ACK) begin
            r_state <= ST_IDLE;
            r_last  <= r_owner;
            r_grant <= 2'b00;
          end else if (!w_own_stb) begin
            r_state <= ST_IDLE;
            r_grant <= 2'b00;
          end
`ifdef WB_ARB_TIMEOUT_EN
          else if (w_expire) begin
            r_state <= ST_TOUT;
          end
`endif
        end
`ifdef WB_ARB_TIMEOUT_EN
        ST_TOUT: begin
          r_state <= ST_IDLE;
          r_last  <= r_owner;
          r_grant <= 2'b00;
        end
`endif
        default: begin
          r_state <= ST_IDLE;
          r_grant <= 2'b00;
        end
      endcase
    end
  end

  assign s_STB   = w_busy & w_own_stb;
  assign s_WE    = w_busy & (r_owner ? m1_WE : m0_WE);
  assign s_ADDR  = w_busy ? (r_owner ? m1_ADDR : m0_ADDR) : '0;
  assign s_DAT_O = w_busy ? (r_owner ? m1_DAT_I : m0_DAT_I) : '0;

  assign m0_ACK   = w_busy & ~r_owner & s_ACK;
  assign m1_ACK   = w_busy & r_owner & s_ACK;
  assign m0_DAT_O = (w_busy & ~r_owner) ? s_DAT_I : '0;
  assign m1_DAT_O = (w_busy & r_owner) ? s_DAT_I : '0;

`ifdef WB_ARB_TIMEOUT_EN
  assign m0_ERR = (r_state == ST_TOUT) & ~r_owner;
  assign m1_ERR = (r_state == ST_TOUT) & r_owner;
`else
  assign m0_ERR = 1'b0;
  assign m1_ERR = 1'b0;
`endif

  assign grant = r_grant;

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed vector table, round-robin and timeout sequences,
// then random traffic against a transaction-level reference model.
module tb_wb_arbiter;
  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int TOUT = 4;
  localparam logic [31:0] DA = 32'hAAAA_0000;
  localparam logic [31:0] DB = 32'h1234_5678;

  logic          clk = 1'b0;
  logic          reset;
  logic          m0_STB, m0_WE, m0_ACK, m0_ERR;
  logic [AW-1:0] m0_ADDR;
  logic [DW-1:0] m0_DAT_I, m0_DAT_O;
  logic          m1_STB, m1_WE, m1_ACK, m1_ERR;
  logic [AW-1:0] m1_ADDR;
  logic [DW-1:0] m1_DAT_I, m1_DAT_O;
  logic          s_STB, s_WE, s_ACK;
  logic [AW-1:0] s_ADDR;
  logic [DW-1:0] s_DAT_O, s_DAT_I;
  logic [1:0]    grant;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  wb_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TOUT)) dut (
    .clk(clk), .reset(reset),
    .m0_STB(m0_STB), .m0_WE(m0_WE), .m0_ADDR(m0_ADDR), .m0_DAT_I(m0_DAT_I),
    .m0_DAT_O(m0_DAT_O), .m0_ACK(m0_ACK), .m0_ERR(m0_ERR),
    .m1_STB(m1_STB), .m1_WE(m1_WE), .m1_ADDR(m1_ADDR), .m1_DAT_I(m1_DAT_I),
    .m1_DAT_O(m1_DAT_O), .m1_ACK(m1_ACK), .m1_ERR(m1_ERR),
    .s_STB(s_STB), .s_WE(s_WE), .s_ADDR(s_ADDR), .s_DAT_O(s_DAT_O),
    .s_DAT_I(s_DAT_I), .s_ACK(s_ACK), .grant(grant)
  );

  typedef struct {
    logic        rst, s0, s1, ack;
    logic [31:0] sdat;
    logic [1:0]  e_grant;
    logic        e_sstb, e_ack0, e_ack1;
    logic [31:0] e_d0, e_d1, e_sdo;
  } vec_t;

  localparam int NV = 28;
  vec_t vecs[NV];

  function automatic vec_t mk(input logic rst, input logic s0, input logic s1, input logic ack,
                              input logic [31:0] sdat, input logic [1:0] eg, input logic es,
                              input logic ea0, input logic ea1, input logic [31:0] ed0,
                              input logic [31:0] ed1, input logic [31:0] esdo);
    vec_t v;
    v.rst = rst; v.s0 = s0; v.s1 = s1; v.ack = ack; v.sdat = sdat;
    v.e_grant = eg; v.e_sstb = es; v.e_ack0 = ea0; v.e_ack1 = ea1;
    v.e_d0 = ed0; v.e_d1 = ed1; v.e_sdo = esdo;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; m0_STB = 1'b0; m1_STB = 1'b0; s_ACK = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // Transaction-level reference state: phase 0 idle, 1 transfer in progress, 2 timeout report.
  int ph, own, last, age, nxfer;

  initial begin
    logic st[2];
    logic [1:0] rr_exp[8];
    int ack_cnt[2];

    reset = 1'b1; m0_STB = 0; m1_STB = 0; m0_WE = 0; m1_WE = 0; s_ACK = 0;
    m0_ADDR = 32'h10; m1_ADDR = 32'h20; m0_DAT_I = DA; m1_DAT_I = DB; s_DAT_I = '0;

    vecs[0]  = mk(0,1,0,0,0,            2'b00,0,0,0,0,0,0);
    vecs[1]  = mk(0,1,0,0,0,            2'b01,1,0,0,0,0,DA);
    vecs[2]  = mk(0,1,0,1,32'hDEADBEEF, 2'b01,1,1,0,32'hDEADBEEF,0,DA);
    vecs[3]  = mk(0,0,0,0,0,            2'b00,0,0,0,0,0,0);
    vecs[4]  = mk(1,0,0,0,0,            2'b00,0,0,0,0,0,0);
    vecs[5]  = mk(0,1,1,0,0,            2'b00,0,0,0,0,0,0);
    vecs[6]  = mk(0,1,1,0,0,            2'b01,1,0,0,0,0,DA);
    vecs[7]  = mk(0,1,1,1,32'h11111111, 2'b01,1,1,0,32'h11111111,0,DA);
    vecs[8]  = mk(0,0,1,0,0,            2'b00,0,0,0,0,0,0);
    vecs[9]  = mk(0,0,1,0,0,            2'b10,1,0,0,0,0,DB);
    vecs[10] = mk(0,0,1,1,32'h22222222, 2'b10,1,0,1,0,32'h22222222,DB);
    vecs[11] = mk(0,0,0,0,0,            2'b00,0,0,0,0,0,0);
    vecs[12] = mk(0,1,0,0,0,            2'b00,0,0,0,0,0,0);
    vecs[13] = mk(0,1,0,0,0,            2'b01,1,0,0,0,0,DA);
    vecs[14] = mk(0,1,0,1,32'h33333333, 2'b01,1,1,0,32'h33333333,0,DA);
    vecs[15] = mk(0,0,1,0,0,            2'b00,0,0,0,0,0,0);
    vecs[16] = mk(0,0,1,0,0,            2'b10,1,0,0,0,0,DB);
    vecs[17] = mk(0,0,1,0,0,            2'b10,1,0,0,0,0,DB);
    vecs[18] = mk(0,0,0,0,0,            2'b10,0,0,0,0,0,DB);
    vecs[19] = mk(0,1,1,0,0,            2'b00,0,0,0,0,0,0);
    vecs[20] = mk(0,1,1,0,0,            2'b10,1,0,0,0,0,DB);
    vecs[21] = mk(0,1,1,1,32'h44444444, 2'b10,1,0,1,0,32'h44444444,DB);
    vecs[22] = mk(0,1,0,0,0,            2'b00,0,0,0,0,0,0);
    vecs[23] = mk(0,1,0,0,0,            2'b01,1,0,0,0,0,DA);
    vecs[24] = mk(1,1,0,0,0,            2'b01,1,0,0,0,0,DA);
    vecs[25] = mk(0,1,0,1,32'h55555555, 2'b00,0,0,0,0,0,0);
    vecs[26] = mk(0,0,0,0,0,            2'b01,0,0,0,0,0,DA);
    vecs[27] = mk(0,0,0,0,0,            2'b00,0,0,0,0,0,0);

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("reset grant", grant, 2'b00);
    chk("reset s_STB", s_STB, 1'b0);
    chk("reset m0_ACK", m0_ACK, 1'b0);
    chk("reset m1_ACK", m1_ACK, 1'b0);
    chk("reset m0_ERR", m0_ERR, 1'b0);
    chk("reset m1_ERR", m1_ERR, 1'b0);
    @(posedge clk);
    #1;

    // Directed vector table: single read, tie, abort, reset mid-transfer
    m1_WE = 1'b1;
    for (int i = 0; i < NV; i++) begin
      reset = vecs[i].rst; m0_STB = vecs[i].s0; m1_STB = vecs[i].s1;
      s_ACK = vecs[i].ack; s_DAT_I = vecs[i].sdat;
      @(negedge clk);
      chk($sformatf("vec%0d grant", i), grant, vecs[i].e_grant);
      chk($sformatf("vec%0d s_STB", i), s_STB, vecs[i].e_sstb);
      chk($sformatf("vec%0d m0_ACK", i), m0_ACK, vecs[i].e_ack0);
      chk($sformatf("vec%0d m1_ACK", i), m1_ACK, vecs[i].e_ack1);
      chk($sformatf("vec%0d m0_ERR", i), m0_ERR, 1'b0);
      chk($sformatf("vec%0d m1_ERR", i), m1_ERR, 1'b0);
      if (vecs[i].e_grant != 2'b00) begin
        chk($sformatf("vec%0d m0_DAT_O", i), m0_DAT_O, vecs[i].e_d0);
        chk($sformatf("vec%0d m1_DAT_O", i), m1_DAT_O, vecs[i].e_d1);
        chk($sformatf("vec%0d s_DAT_O", i), s_DAT_O, vecs[i].e_sdo);
        chk($sformatf("vec%0d s_ADDR", i), s_ADDR, (vecs[i].e_grant == 2'b10) ? 32'h20 : 32'h10);
      end
      $display("vec %0d: grant=%b s_STB=%b m0_ACK=%b m1_ACK=%b", i, grant, s_STB, m0_ACK, m1_ACK);
      @(posedge clk);
      #1;
    end

    // Round-robin under continuous requests from both masters
    do_reset();
    rr_exp = '{2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10};
    ack_cnt[0] = 0; ack_cnt[1] = 0;
    m0_STB = 1'b1; m1_STB = 1'b1; s_ACK = 1'b1;
    for (int i = 0; i < 8; i++) begin
      s_DAT_I = 32'hCAFE_0000 + 32'(i);
      @(negedge clk);
      chk($sformatf("rr%0d grant", i), grant, rr_exp[i]);
      chk($sformatf("rr%0d m1 data on s_DAT_O", i), (s_DAT_O == DB), (rr_exp[i] == 2'b10));
      if (m0_ACK) ack_cnt[0]++;
      if (m1_ACK) ack_cnt[1]++;
      $display("rr %0d: grant=%b s_DAT_O=0x%08h", i, grant, s_DAT_O);
      @(posedge clk);
      #1;
    end
    chk("rr m0 transfers", ack_cnt[0], 2);
    chk("rr m1 transfers", ack_cnt[1], 2);
    m0_STB = 1'b0; m1_STB = 1'b0; s_ACK = 1'b0;

`ifdef WB_ARB_TIMEOUT_EN
    // Timeout: slave silent, then slave acks on the last allowed cycle
    do_reset();
    for (int i = 0; i < 13; i++) begin
      logic [1:0] eg;
      logic es, ea, ee;
      m0_STB = !(i == 6 || i == 12);
      s_ACK  = (i == 11);
      eg = (i >= 1 && i <= 5) || (i >= 8 && i <= 11) ? 2'b01 : 2'b00;
      es = (i >= 1 && i <= 4) || (i >= 8 && i <= 11);
      ea = (i == 11);
      ee = (i == 5);
      @(negedge clk);
      chk($sformatf("tout%0d grant", i), grant, eg);
      chk($sformatf("tout%0d s_STB", i), s_STB, es);
      chk($sformatf("tout%0d m0_ACK", i), m0_ACK, ea);
      chk($sformatf("tout%0d m0_ERR", i), m0_ERR, ee);
      $display("tout %0d: grant=%b s_STB=%b ACK=%b ERR=%b", i, grant, s_STB, m0_ACK, m0_ERR);
      @(posedge clk);
      #1;
    end
    m0_STB = 1'b0; s_ACK = 1'b0;
`endif

    // Random traffic against the reference model
    do_reset();
    ph = 0; last = 1; own = 0; age = 0; nxfer = 0;
    for (int c = 0; c < 1500; c++) begin
      reset  = ($urandom_range(199) == 0);
      m0_STB = m0_STB ? ($urandom_range(15) != 0) : ($urandom_range(2) == 0);
      m1_STB = m1_STB ? ($urandom_range(15) != 0) : ($urandom_range(2) == 0);
      m0_WE = $urandom; m1_WE = $urandom;
      m0_ADDR = $urandom; m1_ADDR = $urandom;
      m0_DAT_I = $urandom; m1_DAT_I = $urandom;
      s_ACK = ($urandom_range(3) == 0);
      s_DAT_I = $urandom;
      st[0] = m0_STB; st[1] = m1_STB;
      @(negedge clk);
      chk("rnd grant", grant, (ph == 0) ? 2'b00 : ((own == 1) ? 2'b10 : 2'b01));
      chk("rnd s_STB", s_STB, (ph == 1) ? st[own] : 1'b0);
      chk("rnd m0_ACK", m0_ACK, (ph == 1 && own == 0 && s_ACK));
      chk("rnd m1_ACK", m1_ACK, (ph == 1 && own == 1 && s_ACK));
      chk("rnd m0_ERR", m0_ERR, (ph == 2 && own == 0));
      chk("rnd m1_ERR", m1_ERR, (ph == 2 && own == 1));
      if (ph == 1) begin
        chk("rnd s_ADDR", s_ADDR, (own == 1) ? m1_ADDR : m0_ADDR);
        chk("rnd s_WE", s_WE, (own == 1) ? m1_WE : m0_WE);
        chk("rnd s_DAT_O", s_DAT_O, (own == 1) ? m1_DAT_I : m0_DAT_I);
        chk("rnd m0_DAT_O", m0_DAT_O, (own == 0) ? s_DAT_I : 32'h0);
        chk("rnd m1_DAT_O", m1_DAT_O, (own == 1) ? s_DAT_I : 32'h0);
      end
      if (reset) begin
        ph = 0; last = 1;
      end else if (ph == 0) begin
        if (st[0] || st[1]) begin
          own = (st[0] && st[1]) ? 1 - last : (st[1] ? 1 : 0);
          ph = 1; age = 0;
        end
      end else if (ph == 1) begin
        if (s_ACK) begin
          last = own; ph = 0; nxfer++;
          $display("rnd xfer %0d: m%0d done data=0x%08h", nxfer, own, s_DAT_I);
        end else if (!st[own]) begin
          ph = 0;
          $display("rnd xfer: m%0d aborted", own);
        end else begin
          age++;
`ifdef WB_ARB_TIMEOUT_EN
          if (age == TOUT) ph = 2;
`endif
        end
      end else begin
        last = own; ph = 0;
        $display("rnd xfer: m%0d timed out", own);
      end
      @(posedge clk);
      #1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
